// File: rtl/irq_trap_ctrl_if.sv
// Core-side bundle for irq_trap_ctrl: CLINT/external request levels, CSR access
// port and the flush/redirect handshake with the pipeline.
interface irq_trap_ctrl_if;
   logic        timer_interrupt_req_in;
   logic        software_interrupt_req_in;
   logic        external_interrupt_req_in;
   logic        csr_we_in;
   logic [11:0] csr_addr_in;
   logic [31:0] csr_wdata_in;
   logic [31:0] csr_rdata_out;
   logic        instr_valid_in;
   logic [31:0] instr_pc_in;
   logic        mret_in;
   logic        flush_req_out;
   logic        flush_ack_in;
   logic        redirect_valid_out;
   logic [31:0] redirect_pc_out;

   modport slave (
      input  timer_interrupt_req_in, software_interrupt_req_in, external_interrupt_req_in,
      input  csr_we_in, csr_addr_in, csr_wdata_in,
      output csr_rdata_out,
      input  instr_valid_in, instr_pc_in, mret_in,
      output flush_req_out,
      input  flush_ack_in,
      output redirect_valid_out, redirect_pc_out
   );

   modport master (
      output timer_interrupt_req_in, software_interrupt_req_in, external_interrupt_req_in,
      output csr_we_in, csr_addr_in, csr_wdata_in,
      input  csr_rdata_out,
      output instr_valid_in, instr_pc_in, mret_in,
      input  flush_req_out,
      output flush_ack_in,
      input  redirect_valid_out, redirect_pc_out
   );
endinterface

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt CSRs (mstatus/mie/mip/mtvec/mepc/mcause) and the
// trap-entry flush -> redirect sequencer, including mret return.
module irq_trap_ctrl #(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
   parameter bit          EXT_SYNC    = 1'b1
) (
   input logic             clk_in,
   input logic             reset_n_in,
   irq_trap_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_TRAP_REDIR,
      S_MRET_REDIR
   } state_e;

   state_e      state_q, state_d;
   logic        mstatus_mie_q, mstatus_mie_d;
   logic        mstatus_mpie_q, mstatus_mpie_d;
   logic [31:0] mie_q, mie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [3:0]  code_q, code_d;

   logic        meip;
   logic [31:0] mip;
   logic [31:0] pending;
   logic [3:0]  code_sel;
   logic [31:0] trap_base;
   logic [31:0] trap_target;
   logic        wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;

   generate
      if (EXT_SYNC) begin : g_ext_sync
         logic [1:0] sync_q;
         always_ff @(posedge clk_in or negedge reset_n_in) begin
            if (!reset_n_in) sync_q <= '0;
            else             sync_q <= {sync_q[0], bus.external_interrupt_req_in};
         end
         assign meip = sync_q[1];
      end else begin : g_ext_bypass
         assign meip = bus.external_interrupt_req_in;
      end
   endgenerate

   always_comb begin
      mip     = '0;
      mip[11] = meip;
      mip[7]  = bus.timer_interrupt_req_in;
      mip[3]  = bus.software_interrupt_req_in;
   end

   assign pending = mip & mie_q & {32{mstatus_mie_q}};

   always_comb begin
      if (pending[11])     code_sel = 4'd11;
      else if (pending[3]) code_sel = 4'd3;
      else                 code_sel = 4'd7;
   end

   assign wr_mstatus = bus.csr_we_in && (bus.csr_addr_in == 12'h300);
   assign wr_mie     = bus.csr_we_in && (bus.csr_addr_in == 12'h304);
   assign wr_mtvec   = bus.csr_we_in && (bus.csr_addr_in == 12'h305);
   assign wr_mepc    = bus.csr_we_in && (bus.csr_addr_in == 12'h341);
   assign wr_mcause  = bus.csr_we_in && (bus.csr_addr_in == 12'h342);

   assign trap_base   = {mtvec_q[31:2], 2'b00};
   assign trap_target = mtvec_q[0] ? trap_base + {26'd0, code_q, 2'b00} : trap_base;

   // CSR writes are applied first; trap/mret updates below then overwrite them.
   always_comb begin
      state_d        = state_q;
      code_d         = code_q;
      mstatus_mie_d  = wr_mstatus ? bus.csr_wdata_in[3] : mstatus_mie_q;
      mstatus_mpie_d = wr_mstatus ? bus.csr_wdata_in[7] : mstatus_mpie_q;
      mie_d          = wr_mie    ? (bus.csr_wdata_in & 32'h0000_0888) : mie_q;
      mtvec_d        = wr_mtvec  ? {bus.csr_wdata_in[31:2], 1'b0, (bus.csr_wdata_in[1:0] == 2'b01)}
                                 : mtvec_q;
      mepc_d         = wr_mepc   ? (bus.csr_wdata_in & ~32'h3) : mepc_q;
      mcause_d       = wr_mcause ? bus.csr_wdata_in : mcause_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.mret_in) begin
               mstatus_mie_d  = mstatus_mpie_q;
               mstatus_mpie_d = 1'b1;
               state_d        = S_MRET_REDIR;
            end else if ((pending != '0) && bus.instr_valid_in) begin
               code_d  = code_sel;
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (bus.flush_ack_in) begin
               mepc_d         = bus.instr_pc_in & ~32'h3;
               mcause_d       = {1'b1, 27'd0, code_q};
               mstatus_mpie_d = mstatus_mie_q;
               mstatus_mie_d  = 1'b0;
               state_d        = S_TRAP_REDIR;
            end
         end
         S_TRAP_REDIR: state_d = S_IDLE;
         S_MRET_REDIR: state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q        <= S_IDLE;
         code_q         <= '0;
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mtvec_q        <= RESET_MTVEC;
         mepc_q         <= '0;
         mcause_q       <= '0;
      end else begin
         state_q        <= state_d;
         code_q         <= code_d;
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_q          <= mie_d;
         mtvec_q        <= mtvec_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
      end
   end

   always_comb begin
      bus.flush_req_out      = (state_q == S_FLUSH);
      bus.redirect_valid_out = (state_q == S_TRAP_REDIR) || (state_q == S_MRET_REDIR);
      bus.redirect_pc_out    = '0;
      if (state_q == S_TRAP_REDIR)      bus.redirect_pc_out = trap_target;
      else if (state_q == S_MRET_REDIR) bus.redirect_pc_out = mepc_q;
   end

   always_comb begin
      bus.csr_rdata_out = '0;
      unique case (bus.csr_addr_in)
         12'h300: bus.csr_rdata_out = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
         12'h304: bus.csr_rdata_out = mie_q;
         12'h305: bus.csr_rdata_out = mtvec_q;
         12'h341: bus.csr_rdata_out = mepc_q;
         12'h342: bus.csr_rdata_out = mcause_q;
         12'h344: bus.csr_rdata_out = mip;
         default: bus.csr_rdata_out = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Self-checking bench for irq_trap_ctrl: directed scenarios plus randomized CSR
// and trap sequences checked against an architectural CSR model.
module tb_irq_trap_ctrl;

   logic clk;
   logic rst_n;
   irq_trap_ctrl_if bus ();

   irq_trap_ctrl #(.RESET_MTVEC(32'h0000_0100), .EXT_SYNC(1'b1)) dut (
      .clk_in     (clk),
      .reset_n_in (rst_n),
      .bus        (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // architectural model state
   logic        m_mie_bit, m_mpie;
   logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause;

   function automatic logic [31:0] m_mip();
      return (32'(bus.external_interrupt_req_in) << 11) |
             (32'(bus.timer_interrupt_req_in) << 7) |
             (32'(bus.software_interrupt_req_in) << 3);
   endfunction

   function automatic logic [31:0] exp_rd(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie_bit) << 3);
         12'h304: return m_mie;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h344: return m_mip();
         default: return 32'h0;
      endcase
   endfunction

   function automatic void model_write(input logic [11:0] a, input logic [31:0] d);
      case (a)
         12'h300: begin m_mie_bit = d[3]; m_mpie = d[7]; end
         12'h304: m_mie = d & 32'h888;
         12'h305: m_mtvec = (d & ~32'h3) | ((d[1:0] == 2'b01) ? 32'h1 : 32'h0);
         12'h341: m_mepc = d & ~32'h3;
         12'h342: m_mcause = d;
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] model_target(input int unsigned code);
      logic [31:0] base;
      base = m_mtvec & ~32'h3;
      return m_mtvec[0] ? base + 32'(4 * code) : base;
   endfunction

   function automatic int unsigned model_code(input logic [31:0] pend);
      if (pend[11]) return 11;
      if (pend[3])  return 3;
      return 7;
   endfunction

   function automatic void model_trap(input logic [31:0] pc, input int unsigned code);
      m_mepc    = pc & ~32'h3;
      m_mcause  = 32'h8000_0000 | 32'(code);
      m_mpie    = m_mie_bit;
      m_mie_bit = 1'b0;
   endfunction

   function automatic void model_reset();
      m_mie_bit = 0; m_mpie = 0; m_mie = 0; m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      bus.csr_we_in = 1'b1; bus.csr_addr_in = a; bus.csr_wdata_in = d;
      tick();
      bus.csr_we_in = 1'b0;
      model_write(a, d);
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] d);
      bus.csr_addr_in = a;
      #1;
      d = bus.csr_rdata_out;
   endtask

   task automatic set_req(input logic t, input logic s, input logic e);
      bus.timer_interrupt_req_in = t; bus.software_interrupt_req_in = s;
      bus.external_interrupt_req_in = e;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [11:0] addrs [6] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344};
      rst_n = 1'b0;
      set_req(0, 0, 0);
      bus.csr_we_in = 0; bus.csr_addr_in = '0; bus.csr_wdata_in = '0;
      bus.instr_valid_in = 0; bus.instr_pc_in = '0; bus.mret_in = 0; bus.flush_ack_in = 0;
      model_reset();
      #12;
      n_checks++; if (bus.flush_req_out !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b exp 0", bus.flush_req_out); end
      n_checks++; if (bus.redirect_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_redir got %b exp 0", bus.redirect_valid_out); end
      n_checks++; if (bus.redirect_pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_redir_pc got %h exp 0", bus.redirect_pc_out); end
      foreach (addrs[i]) begin
         rd(addrs[i], d);
         n_checks++; if (d !== exp_rd(addrs[i])) begin n_fail++; $display("FAIL reset_csr_%h got %h exp %h", addrs[i], d, exp_rd(addrs[i])); end
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_csr_fields();
      logic [31:0] d;
      wr(12'h341, 32'h2003); rd(12'h341, d);
      n_checks++; if (d !== 32'h2000) begin n_fail++; $display("FAIL mepc_align got %h exp 00002000", d); end
      wr(12'h344, 32'hFFFF_FFFF); rd(12'h344, d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mip_readonly got %h exp 0", d); end
      rd(12'h7C0, d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped got %h exp 0", d); end
      wr(12'h304, 32'hFFFF_FFFF); rd(12'h304, d);
      n_checks++; if (d !== 32'h888) begin n_fail++; $display("FAIL mie_mask got %h exp 888", d); end
      wr(12'h300, 32'hFFFF_FFFF); rd(12'h300, d);
      n_checks++; if (d !== 32'h1888) begin n_fail++; $display("FAIL mstatus_mask got %h exp 1888", d); end
      wr(12'h305, 32'h0000_0103); rd(12'h305, d);
      n_checks++; if (d !== 32'h100) begin n_fail++; $display("FAIL mtvec_mode3 got %h exp 100", d); end
      wr(12'h305, 32'h0000_0102); rd(12'h305, d);
      n_checks++; if (d !== 32'h100) begin n_fail++; $display("FAIL mtvec_mode2 got %h exp 100", d); end
      wr(12'h342, 32'hDEAD_BEEF); rd(12'h342, d);
      n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mcause_full got %h exp deadbeef", d); end
      wr(12'h300, 32'h0); wr(12'h304, 32'h0);
   endtask

   task automatic test_timer_trap();
      logic [31:0] d;
      wr(12'h304, 32'h80); wr(12'h300, 32'h8);
      set_req(1, 0, 0); bus.instr_valid_in = 1; bus.instr_pc_in = 32'h2000;
      tick();
      n_checks++; if (bus.flush_req_out !== 1'b1) begin n_fail++; $display("FAIL t1_flush got %b exp 1", bus.flush_req_out); end
      bus.mret_in = 1; tick(); bus.mret_in = 0; tick();
      n_checks++; if (bus.flush_req_out !== 1'b1 || bus.redirect_valid_out !== 1'b0) begin n_fail++; $display("FAIL t1_hold flush %b redir %b exp 1/0", bus.flush_req_out, bus.redirect_valid_out); end
      bus.flush_ack_in = 1; tick(); bus.flush_ack_in = 0;
      model_trap(32'h2000, 7);
      n_checks++; if (bus.redirect_valid_out !== 1'b1 || bus.redirect_pc_out !== 32'h100) begin n_fail++; $display("FAIL t1_redirect got %b/%h exp 1/00000100", bus.redirect_valid_out, bus.redirect_pc_out); end
      n_checks++; if (bus.flush_req_out !== 1'b0) begin n_fail++; $display("FAIL t1_flush_drop got %b exp 0", bus.flush_req_out); end
      tick();
      n_checks++; if (bus.redirect_valid_out !== 1'b0 || bus.redirect_pc_out !== 32'h0) begin n_fail++; $display("FAIL t1_redirect_pulse got %b/%h exp 0/0", bus.redirect_valid_out, bus.redirect_pc_out); end
      rd(12'h341, d); n_checks++; if (d !== 32'h2000) begin n_fail++; $display("FAIL t1_mepc got %h exp 00002000", d); end
      rd(12'h342, d); n_checks++; if (d !== 32'h8000_0007) begin n_fail++; $display("FAIL t1_mcause got %h exp 80000007", d); end
      rd(12'h300, d); n_checks++; if (d !== 32'h1880) begin n_fail++; $display("FAIL t1_mstatus got %h exp 1880", d); end
   endtask

   task automatic test_mret();
      logic [31:0] d;
      bus.mret_in = 1; bus.instr_pc_in = 32'h2400; tick(); bus.mret_in = 0;
      m_mie_bit = m_mpie; m_mpie = 1;
      n_checks++; if (bus.redirect_valid_out !== 1'b1 || bus.redirect_pc_out !== 32'h2000) begin n_fail++; $display("FAIL mret_redirect got %b/%h exp 1/00002000", bus.redirect_valid_out, bus.redirect_pc_out); end
      rd(12'h300, d); n_checks++; if (d !== 32'h1888) begin n_fail++; $display("FAIL mret_mstatus got %h exp 1888", d); end
      tick();
      n_checks++; if (bus.redirect_valid_out !== 1'b0 || bus.flush_req_out !== 1'b0) begin n_fail++; $display("FAIL mret_gap redir %b flush %b exp 0/0", bus.redirect_valid_out, bus.flush_req_out); end
      tick();
      n_checks++; if (bus.flush_req_out !== 1'b1) begin n_fail++; $display("FAIL mret_retrap got %b exp 1", bus.flush_req_out); end
      bus.flush_ack_in = 1; tick(); bus.flush_ack_in = 0;
      model_trap(32'h2400, 7);
      n_checks++; if (bus.redirect_pc_out !== model_target(7)) begin n_fail++; $display("FAIL mret_retrap_pc got %h exp %h", bus.redirect_pc_out, model_target(7)); end
      set_req(0, 0, 0); bus.instr_valid_in = 0;
      tick();
   endtask

   task automatic test_priority_vectored();
      logic [31:0] d;
      bus.instr_valid_in = 0;
      wr(12'h305, 32'h201); wr(12'h304, 32'h888); wr(12'h300, 32'h8);
      set_req(1, 1, 1);
      tick(); tick(); tick();
      rd(12'h344, d); n_checks++; if (d !== 32'h888) begin n_fail++; $display("FAIL t2_mip got %h exp 888", d); end
      bus.instr_valid_in = 1; bus.instr_pc_in = 32'h5000;
      tick();
      n_checks++; if (bus.flush_req_out !== 1'b1) begin n_fail++; $display("FAIL t2_flush got %b exp 1", bus.flush_req_out); end
      bus.flush_ack_in = 1; tick(); bus.flush_ack_in = 0;
      n_checks++; if (bus.redirect_pc_out !== 32'h22C) begin n_fail++; $display("FAIL t2_vector got %h exp 0000022c", bus.redirect_pc_out); end
      model_trap(32'h5000, 11);
      rd(12'h342, d); n_checks++; if (d !== 32'h8000_000B) begin n_fail++; $display("FAIL t2_mcause got %h exp 8000000b", d); end
      set_req(0, 0, 0); bus.instr_valid_in = 0;
      tick(); tick(); tick();
   endtask

   task automatic test_masked();
      logic [31:0] d;
      int unsigned seen;
      wr(12'h300, 32'h0); wr(12'h304, 32'h80);
      set_req(1, 0, 0); bus.instr_valid_in = 1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.flush_req_out !== 1'b0) seen++;
      end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL t4_masked flush cycles %0d exp 0", seen); end
      rd(12'h344, d); n_checks++; if (d !== 32'h80) begin n_fail++; $display("FAIL t4_mip got %h exp 80", d); end
      set_req(0, 0, 0); bus.instr_valid_in = 0;
   endtask

   task automatic test_ext_latency();
      wr(12'h305, 32'h300); wr(12'h304, 32'h800); wr(12'h300, 32'h8);
      bus.instr_valid_in = 1; bus.instr_pc_in = 32'h7000;
      set_req(0, 0, 1);
      tick(); tick();
      n_checks++; if (bus.flush_req_out !== 1'b0) begin n_fail++; $display("FAIL ext_early got %b exp 0", bus.flush_req_out); end
      tick();
      n_checks++; if (bus.flush_req_out !== 1'b1) begin n_fail++; $display("FAIL ext_latency got %b exp 1", bus.flush_req_out); end
      bus.flush_ack_in = 1; tick(); bus.flush_ack_in = 0;
      n_checks++; if (bus.redirect_pc_out !== 32'h300) begin n_fail++; $display("FAIL ext_redirect got %h exp 00000300", bus.redirect_pc_out); end
      model_trap(32'h7000, 11);
      set_req(0, 0, 0); bus.instr_valid_in = 0;
      tick(); tick(); tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      wr(12'h304, 32'h80); wr(12'h300, 32'h8);
      set_req(1, 0, 0);
      bus.flush_ack_in = 1; tick(); bus.flush_ack_in = 0;
      n_checks++; if (bus.redirect_valid_out !== 1'b0 || bus.flush_req_out !== 1'b0) begin n_fail++; $display("FAIL stray_ack redir %b flush %b exp 0/0", bus.redirect_valid_out, bus.flush_req_out); end
      bus.instr_valid_in = 1; bus.instr_pc_in = 32'h3006;
      wr(12'h300, 32'h0);
      n_checks++; if (bus.flush_req_out !== 1'b1) begin n_fail++; $display("FAIL mie_clear_race got %b exp 1", bus.flush_req_out); end
      bus.mret_in = 1; tick(); bus.mret_in = 0;
      rd(12'h300, d); n_checks++; if (d !== 32'h1800 || bus.flush_req_out !== 1'b1) begin n_fail++; $display("FAIL mret_in_flush mstatus %h flush %b exp 1800/1", d, bus.flush_req_out); end
      bus.flush_ack_in = 1; bus.csr_we_in = 1; bus.csr_addr_in = 12'h342; bus.csr_wdata_in = 32'hDEAD_BEEF;
      tick();
      bus.flush_ack_in = 0; bus.csr_we_in = 0;
      model_trap(32'h3006, 7);
      n_checks++; if (bus.redirect_pc_out !== model_target(7)) begin n_fail++; $display("FAIL b2b_redirect got %h exp %h", bus.redirect_pc_out, model_target(7)); end
      rd(12'h342, d); n_checks++; if (d !== 32'h8000_0007) begin n_fail++; $display("FAIL trap_wins_mcause got %h exp 80000007", d); end
      rd(12'h341, d); n_checks++; if (d !== 32'h3004) begin n_fail++; $display("FAIL b2b_mepc got %h exp 00003004", d); end
      set_req(0, 0, 0); bus.instr_valid_in = 0;
      tick();
   endtask

   task automatic test_random_csr();
      logic [31:0] d, v;
      logic [11:0] a;
      logic [11:0] addrs [7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h123};
      for (int i = 0; i < 30; i++) begin
         a = addrs[$urandom_range(0, 6)];
         v = $urandom;
         wr(a, v);
         rd(a, d);
         n_checks++; if (d !== exp_rd(a)) begin n_fail++; $display("FAIL rnd_csr_%h wrote %h got %h exp %h", a, v, d, exp_rd(a)); end
      end
   endtask

   task automatic test_random_trap();
      logic [31:0] d, pend, pc, tgt;
      logic [2:0]  req;
      int unsigned code;
      for (int i = 0; i < 25; i++) begin
         bus.instr_valid_in = 0;
         wr(12'h305, $urandom);
         wr(12'h304, $urandom);
         wr(12'h300, $urandom | 32'h8);
         req = 3'($urandom);
         set_req(req[0], req[1], req[2]);
         tick(); tick(); tick();
         rd(12'h344, d);
         n_checks++; if (d !== m_mip()) begin n_fail++; $display("FAIL rnd_mip got %h exp %h", d, m_mip()); end
         pend = m_mip() & m_mie;
         pc = $urandom;
         bus.instr_pc_in = pc; bus.instr_valid_in = 1;
         tick();
         if (pend == 0) begin
            n_checks++; if (bus.flush_req_out !== 1'b0) begin n_fail++; $display("FAIL rnd_notrap got %b exp 0", bus.flush_req_out); end
         end else begin
            code = model_code(pend);
            n_checks++; if (bus.flush_req_out !== 1'b1) begin n_fail++; $display("FAIL rnd_flush got %b exp 1", bus.flush_req_out); end
            if ($urandom_range(0, 1) == 1) set_req(0, 0, 0);
            repeat ($urandom_range(0, 3)) tick();
            bus.flush_ack_in = 1; tick(); bus.flush_ack_in = 0;
            model_trap(pc, code);
            tgt = model_target(code);
            n_checks++; if (bus.redirect_valid_out !== 1'b1 || bus.redirect_pc_out !== tgt) begin n_fail++; $display("FAIL rnd_redirect got %b/%h exp 1/%h", bus.redirect_valid_out, bus.redirect_pc_out, tgt); end
            bus.instr_valid_in = 0;
            tick();
            rd(12'h342, d); n_checks++; if (d !== m_mcause) begin n_fail++; $display("FAIL rnd_mcause got %h exp %h", d, m_mcause); end
            rd(12'h341, d); n_checks++; if (d !== m_mepc) begin n_fail++; $display("FAIL rnd_mepc got %h exp %h", d, m_mepc); end
            rd(12'h300, d); n_checks++; if (d !== exp_rd(12'h300)) begin n_fail++; $display("FAIL rnd_mstatus got %h exp %h", d, exp_rd(12'h300)); end
         end
         bus.instr_valid_in = 0;
         set_req(0, 0, 0);
         wr(12'h300, 32'h0);
         tick(); tick();
      end
   endtask

   task automatic test_reset_mid_flush();
      logic [31:0] d;
      int unsigned seen;
      wr(12'h305, 32'h301); wr(12'h304, 32'h80); wr(12'h300, 32'h8);
      set_req(1, 0, 0); bus.instr_valid_in = 1; bus.instr_pc_in = 32'h9000;
      tick(); tick();
      n_checks++; if (bus.flush_req_out !== 1'b1) begin n_fail++; $display("FAIL t5_in_flush got %b exp 1", bus.flush_req_out); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.flush_req_out !== 1'b0) begin n_fail++; $display("FAIL t5_async_flush got %b exp 0", bus.flush_req_out); end
      model_reset();
      bus.flush_ack_in = 1;
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.redirect_valid_out !== 1'b0 || bus.flush_req_out !== 1'b0) seen++;
      end
      bus.flush_ack_in = 0;
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL t5_residue active cycles %0d exp 0", seen); end
      rd(12'h305, d); n_checks++; if (d !== 32'h100) begin n_fail++; $display("FAIL t5_mtvec got %h exp 00000100", d); end
      rd(12'h300, d); n_checks++; if (d !== 32'h1800) begin n_fail++; $display("FAIL t5_mstatus got %h exp 1800", d); end
      rd(12'h304, d); n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL t5_mie got %h exp 0", d); end
      set_req(0, 0, 0); bus.instr_valid_in = 0;
   endtask

   initial begin
      test_reset();
      test_csr_fields();
      test_timer_trap();
      test_mret();
      test_priority_vectored();
      test_masked();
      test_ext_latency();
      test_back_to_back();
      test_random_csr();
      test_random_trap();
      test_reset_mid_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
